// File: rtl/acq_pkg.sv
// Shared types and defaults for the PSRAM acquisition write sequencer.
package acq_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 22;
    localparam logic [21:0] LAST_ADDR_DEF = 22'h3FFFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_CAL,
        S_RUN,
        S_WRITE,
        S_DRAIN,
        S_DONE
    } state_t;
endpackage

// File: rtl/psram_acq_writer_if.sv
// PSRAM write handshake: master issues req/addr/data, controller answers with ack.
interface psram_acq_writer_if
    import acq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              wr_req_o;
    logic [ADDR_W-1:0] wr_addr_o;
    logic [DATA_W-1:0] wr_data_o;
    logic              wr_ack_i;

    modport master (output wr_req_o, wr_addr_o, wr_data_o, input wr_ack_i);
    modport slave  (input wr_req_o, wr_addr_o, wr_data_o, output wr_ack_i);
endinterface

// File: rtl/acq_sync_fifo.sv
// Single-clock sample FIFO with flop storage, flush, and same-cycle push/pop when full.
module acq_sync_fifo #(
    parameter int DATA_W  = 16,
    parameter int FIFO_AW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
    localparam logic [FIFO_AW:0]   CNT_ONE = (FIFO_AW+1)'(1);

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               do_push;
    logic               do_pop;

    assign full    = count[FIFO_AW];
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    // A pop in the same cycle frees the head slot, so a push into a full FIFO still lands.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/psram_acq_writer.sv
// Acquisition write sequencer: buffers ADC samples and writes them to PSRAM at a
// linear or circular 22-bit word address, exporting the live address for the debug probe.
module psram_acq_writer
    import acq_pkg::*;
#(
    parameter int                DATA_W    = DATA_W_DEF,
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LAST_ADDR_DEF),
    parameter int                FIFO_AW   = 4
) (
    input  logic                clk_PSRAM,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic                stop_i,
    input  logic                circ_i,
    input  logic                calib_done_i,
    input  logic [DATA_W-1:0]   sample_i,
    input  logic                sample_valid_i,
    psram_acq_writer_if.master  wr,
    output logic [ADDR_W-1:0]   addr_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                overflow_o
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d, fifo_head;
    logic              circ_q, circ_d, stop_q, stop_d, req_q, req_d;
    logic              done_q, done_d, ovf_q, ovf_d;
    logic              accept, issue, fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;

    acq_sync_fifo #(.DATA_W(DATA_W), .FIFO_AW(FIFO_AW)) u_fifo (
        .clk       (clk_PSRAM),
        .rst_n     (rst_n),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (sample_i),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk_PSRAM or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            circ_q    <= 1'b0;
            stop_q    <= 1'b0;
            req_q     <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            circ_q    <= circ_d;
            stop_q    <= stop_d;
            req_q     <= req_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        circ_d     = circ_q;
        stop_d     = stop_q;
        req_d      = req_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = done_q;
        ovf_d      = ovf_q;
        issue      = 1'b0;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
        // Once stop is seen no further samples enter, so only what was queued gets drained.
        accept     = (state_q == S_RUN || state_q == S_WRITE) && !stop_q && !stop_i;
        fifo_push  = accept && sample_valid_i;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d    = S_WAIT_CAL;
                    addr_d     = '0;
                    circ_d     = circ_i;
                    stop_d     = 1'b0;
                    done_d     = 1'b0;
                    ovf_d      = 1'b0;
                    fifo_flush = 1'b1;
                end
            end
            S_WAIT_CAL: begin
                if (stop_i) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (calib_done_i) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (stop_i) begin
                    state_d = S_DRAIN;
                    stop_d  = 1'b1;
                end else if (!fifo_empty) begin
                    issue = 1'b1;
                end
            end
            S_DRAIN: begin
                if (!fifo_empty) begin
                    issue = 1'b1;
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_WRITE: begin
                if (stop_i) stop_d = 1'b1;
                if (wr.wr_ack_i) begin
                    req_d = 1'b0;
                    // End of a linear capture beats a simultaneous stop; leftovers are discarded.
                    if (addr_q == LAST_ADDR && !circ_q) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        fifo_flush = 1'b1;
                    end else begin
                        addr_d  = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
                        state_d = (stop_q || stop_i) ? S_DRAIN : S_RUN;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (issue) begin
            fifo_pop  = 1'b1;
            req_d     = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = fifo_head;
            state_d   = S_WRITE;
        end
        if (fifo_push && fifo_full && !fifo_pop && !fifo_flush) ovf_d = 1'b1;
    end

    assign wr.wr_req_o  = req_q;
    assign wr.wr_addr_o = wr_addr_q;
    assign wr.wr_data_o = wr_data_q;
    assign addr_o       = addr_q;
    assign busy_o       = state_q inside {S_WAIT_CAL, S_RUN, S_WRITE, S_DRAIN};
    assign done_o       = done_q;
    assign overflow_o   = ovf_q;
endmodule
